cnt_sweep_ctrl: RTL and testbench

CNT_SWEEP_CTRL -- requirements
Module: cnt_sweep_ctrl

---
 rtl/cnt_pkg.sv | 16 +
 rtl/cnt_core.sv | 26 ++
 rtl/cnt_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_cnt_sweep_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared state encoding and constants for the sweep counter
package cnt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        DONE
    } cnt_state_t;

    localparam int   CNT_WIDTH = 4;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

endpackage

// File: rtl/cnt_core.sv
// rtl/cnt_core.sv - loadable up/down counter; load has priority over count enable
module cnt_core
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             cnt_clk,
    input  logic             cnt_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge cnt_clk or negedge cnt_rst) begin
        if (!cnt_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/cnt_sweep_ctrl.sv
// rtl/cnt_sweep_ctrl.sv - command-driven triangle sweep between a latched floor and ceiling
module cnt_sweep_ctrl
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int HOLD  = 2
) (
    input  logic             cnt_clk,
    input  logic             cnt_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_lo,
    input  logic [WIDTH-1:0] cmd_hi,
    input  logic [2:0]       cmd_sweeps,
    input  logic             abort,
    output logic [WIDTH-1:0] count_out,
    output logic             cnt_dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       sweep_idx
);

    localparam logic [2:0] HOLD_LAST = 3'(HOLD - 1);

    cnt_state_t       state, state_nxt;
    logic [WIDTH-1:0] lo_r, hi_r;
    logic [2:0]       sweeps_r;
    logic [2:0]       idx_r, idx_nxt;
    logic [2:0]       hold_r, hold_nxt;
    logic             err_r, err_nxt;
    logic             latch;
    logic             ld, en, dir;
    logic [WIDTH-1:0] ld_val;
    logic             handshake, cmd_bad;

    assign cmd_ready = (state == IDLE) && !abort;
    assign handshake = cmd_valid && cmd_ready;
    assign cmd_bad   = (cmd_lo >= cmd_hi) || (cmd_sweeps == 3'd0);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_r;
        hold_nxt  = hold_r;
        err_nxt   = 1'b0;
        latch     = 1'b0;
        ld        = 1'b0;
        ld_val    = lo_r;
        en        = 1'b0;
        dir       = DIR_UP;
        // Abort freezes the counter and sweep index where they stand.
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (cmd_bad) begin
                            err_nxt = 1'b1;
                        end else begin
                            latch     = 1'b1;
                            ld        = 1'b1;
                            ld_val    = cmd_lo;
                            idx_nxt   = 3'd0;
                            state_nxt = UP;
                        end
                    end
                end
                UP: begin
                    if (count_out == hi_r) begin
                        hold_nxt  = 3'd0;
                        state_nxt = HOLD_HI;
                    end else begin
                        en = 1'b1;
                    end
                end
                HOLD_HI: begin
                    if (hold_r == HOLD_LAST) begin
                        en        = 1'b1;
                        dir       = DIR_DOWN;
                        state_nxt = DOWN;
                    end else begin
                        hold_nxt = hold_r + 3'd1;
                    end
                end
                DOWN: begin
                    if (count_out == lo_r) begin
                        idx_nxt = idx_r + 3'd1;
                        // Later sweeps restart at lo+1 so the floor is not repeated.
                        if (({1'b0, idx_r} + 4'd1) < {1'b0, sweeps_r}) begin
                            ld        = 1'b1;
                            ld_val    = lo_r + 1'b1;
                            state_nxt = UP;
                        end else begin
                            state_nxt = DONE;
                        end
                    end else begin
                        en  = 1'b1;
                        dir = DIR_DOWN;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge cnt_clk or negedge cnt_rst) begin
        if (!cnt_rst) begin
            state    <= IDLE;
            lo_r     <= '0;
            hi_r     <= '0;
            sweeps_r <= 3'd0;
            idx_r    <= 3'd0;
            hold_r   <= 3'd0;
            err_r    <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx_r  <= idx_nxt;
            hold_r <= hold_nxt;
            err_r  <= err_nxt;
            if (latch) begin
                lo_r     <= cmd_lo;
                hi_r     <= cmd_hi;
                sweeps_r <= cmd_sweeps;
            end
        end
    end

    cnt_core #(.WIDTH(WIDTH)) u_core (
        .cnt_clk  (cnt_clk),
        .cnt_rst  (cnt_rst),
        .load     (ld),
        .load_val (ld_val),
        .en       (en),
        .dir      (dir),
        .count    (count_out)
    );

    assign busy      = (state != IDLE);
    assign cnt_dir   = (state == UP || state == HOLD_HI) ? DIR_UP : DIR_DOWN;
    assign done      = (state == DONE) && !abort;
    assign err       = err_r;
    assign sweep_idx = idx_r;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// tb/tb_cnt_sweep_ctrl.sv - scoreboard bench for cnt_sweep_ctrl against a trace-level sweep model
module tb_cnt_sweep_ctrl;

    localparam int WIDTH = 4;
    localparam int HOLD  = 2;

    typedef struct packed {
        logic [3:0] count;
        logic       dir;
        logic [2:0] idx;
        logic       done;
        logic       err;
    } exp_t;

    logic             cnt_clk = 1'b0;
    logic             cnt_rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_lo;
    logic [WIDTH-1:0] cmd_hi;
    logic [2:0]       cmd_sweeps;
    logic             abort;
    logic [WIDTH-1:0] count_out;
    logic             cnt_dir;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       sweep_idx;

    int   n_checks    = 0;
    int   n_pass      = 0;
    int   model_count = 0;
    int   model_idx   = 0;
    exp_t sb[$];
    exp_t trace[$];

    cnt_sweep_ctrl #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .cnt_clk    (cnt_clk),
        .cnt_rst    (cnt_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_lo     (cmd_lo),
        .cmd_hi     (cmd_hi),
        .cmd_sweeps (cmd_sweeps),
        .abort      (abort),
        .count_out  (count_out),
        .cnt_dir    (cnt_dir),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_idx  (sweep_idx)
    );

    always #5 cnt_clk = ~cnt_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s act=%0h req=%0h", name, act, req);
    endtask

    function automatic exp_t mk(input int c, input logic d, input int i, input logic dn, input logic e);
        exp_t x;
        x.count = 4'(c);
        x.dir   = d;
        x.idx   = 3'(i);
        x.done  = dn;
        x.err   = e;
        return x;
    endfunction

    // Every busy cycle (and every err pulse) is one expected sample.
    initial begin
        forever begin
            @(negedge cnt_clk);
            if (cnt_rst === 1'b1 && (busy === 1'b1 || err === 1'b1)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output act=%h req=none",
                             {count_out, cnt_dir, sweep_idx, done, err});
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sample", 32'({count_out, cnt_dir, sweep_idx, done, err}), 32'(e));
                end
            end
        end
    end

    // kind: 0 run to completion, 1 abort after cut cycles, 2 reset after cut cycles; cut 0 = random
    task automatic send(input int lo, input int hi, input int n, input int kind, input int cut);
        int   c;
        int   i;
        exp_t x;
        cmd_lo     = 4'(lo);
        cmd_hi     = 4'(hi);
        cmd_sweeps = 3'(n);
        cmd_valid  = 1'b1;
        if (lo >= hi || n == 0) begin
            sb.push_back(mk(model_count, 1'b0, model_idx, 1'b0, 1'b1));
            @(posedge cnt_clk); #1;
            cmd_valid = 1'b0;
            chk("reject_busy", 32'(busy), 32'd0);
            @(posedge cnt_clk); #1;
            chk("reject_count", 32'(count_out), 32'(model_count));
            return;
        end
        trace.delete();
        for (int s = 0; s < n; s++) begin
            for (int v = (s == 0 ? lo : lo + 1); v <= hi; v++) trace.push_back(mk(v, 1'b1, s, 1'b0, 1'b0));
            for (int h = 0; h < HOLD; h++) trace.push_back(mk(hi, 1'b1, s, 1'b0, 1'b0));
            for (int v = hi - 1; v >= lo; v--) trace.push_back(mk(v, 1'b0, s, 1'b0, 1'b0));
        end
        trace.push_back(mk(lo, 1'b0, n, 1'b1, 1'b0));
        c = cut;
        if (kind != 0) begin
            if (c == 0) c = $urandom_range(1, trace.size());
            while (trace.size() > c) void'(trace.pop_back());
        end
        if (kind == 1) begin
            x = trace[c-1];
            x.done = 1'b0;
            trace[c-1] = x;
        end
        foreach (trace[j]) sb.push_back(trace[j]);
        @(posedge cnt_clk); #1;
        cmd_valid = 1'b0;
        if (kind == 1) begin
            repeat (c - 1) @(posedge cnt_clk);
            #1 abort = 1'b1;
            @(posedge cnt_clk); #1;
            abort = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_count", 32'(count_out), 32'(trace[c-1].count));
            chk("abort_idx", 32'(sweep_idx), 32'(trace[c-1].idx));
            model_count = int'(trace[c-1].count);
            model_idx   = int'(trace[c-1].idx);
        end else if (kind == 2) begin
            repeat (c) @(posedge cnt_clk);
            #1 cnt_rst = 1'b0;
            #1;
            chk("rst_count", 32'(count_out), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_flags", 32'({cnt_dir, done, err, sweep_idx}), 32'd0);
            chk("rst_ready", 32'(cmd_ready), 32'd1);
            model_count = 0;
            model_idx   = 0;
        end else begin
            i = 0;
            while ((busy === 1'b1 || sb.size() != 0) && i < 3000) begin
                @(posedge cnt_clk); #1;
                i++;
                if (busy === 1'b1) begin
                    cmd_valid  = 1'($urandom);
                    cmd_lo     = 4'($urandom);
                    cmd_hi     = 4'($urandom);
                    cmd_sweeps = 3'($urandom);
                end
            end
            cmd_valid = 1'b0;
            if (i >= 3000) begin
                n_checks++;
                $display("FAIL wait_timeout busy=%0b pending=%0d req=idle", busy, sb.size());
            end
            model_count = lo;
            model_idx   = n;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lo, hi, n, kind, tmp;
        cnt_rst    = 1'b0;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_lo     = '0;
        cmd_hi     = '0;
        cmd_sweeps = '0;
        #3;
        chk("reset_count", 32'(count_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_flags", 32'({cnt_dir, done, err, sweep_idx}), 32'd0);
        repeat (2) @(posedge cnt_clk);
        #1 cnt_rst = 1'b1;

        send(2, 5, 1, 0, 0);
        send(0, 1, 3, 0, 0);
        send(5, 5, 1, 0, 0);
        send(3, 9, 0, 0, 0);
        send(2, 5, 1, 1, 6);
        send(3, 7, 2, 0, 0);

        cmd_lo     = 4'd1;
        cmd_hi     = 4'd3;
        cmd_sweeps = 3'd1;
        cmd_valid  = 1'b1;
        abort      = 1'b1;
        #1;
        chk("abort_idle_ready", 32'(cmd_ready), 32'd0);
        @(posedge cnt_clk); #1;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_count", 32'(count_out), 32'(model_count));
        abort     = 1'b0;
        cmd_valid = 1'b0;

        send(2, 5, 1, 2, 7);
        @(posedge cnt_clk); #1;
        chk("rst_hold_count", 32'(count_out), 32'd0);
        cnt_rst = 1'b1;
        send(1, 4, 1, 0, 0);
        send(0, 15, 1, 0, 0);

        for (int r = 0; r < 40; r++) begin
            lo = $urandom_range(0, 15);
            hi = $urandom_range(0, 15);
            n  = $urandom_range(0, 7);
            if ($urandom_range(0, 5) != 0) begin
                if (lo > hi) begin
                    tmp = lo;
                    lo  = hi;
                    hi  = tmp;
                end
                if (lo == hi) begin
                    if (hi < 15) hi++;
                    else lo--;
                end
                if (n == 0) n = 1;
            end
            kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
            send(lo, hi, n, kind, 0);
        end

        repeat (3) @(posedge cnt_clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_idle", 32'(busy), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
